ifetch16: RTL

- Instruction-fetch front end for the RiSC-16 core. Consumes the registered program counter and drives the PC's `enable` input, so the PC advances only when a fetch is actually issued or a redirect occurs.
- Issues in-order read requests to instruction memory over a valid/ready request channel and accepts fixed-order responses.
- Buffers fetched instructions, each tagged with its PC, in a small FIFO and presents them to decode over a valid/ready handshake.
- On a redirect (taken branch or jalr), it flushes the buffer and discards wrong-path responses still in flight.

---
 rtl/ifetch16.sv | 118 +++++++++++
 1 files changed

// File: rtl/ifetch16.sv
// ifetch16 -- instruction-fetch front end for the RiSC-16 core.
//
// Issues in-order fetches at the registered PC and drives the PC enable so
// the PC only moves when a fetch is issued or a redirect loads a target.
// Returned instructions are tagged with their PC, buffered in a small FIFO
// and handed to decode over a valid/ready handshake. A redirect flushes the
// buffer and arranges for all responses still in flight to be dropped.
//
// Ports:
//   clk, reset                    clock (rising edge), async active-high reset
//   pc                            current PC from the PC register
//   pc_enable                     PC loads its next value this edge
//   redirect                      one-cycle flush pulse from decode
//   imem_req_valid/ready/addr     fetch request channel (addr == pc)
//   imem_rsp_valid/data           in-order read responses, no backpressure
//   inst_valid/ready/data/pc      buffered instruction towards decode
module ifetch16 #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc,
   output logic        pc_enable,
   input  logic        redirect,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [15:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [15:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [15:0] inst_data,
   output logic [15:0] inst_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [CW-1:0] in_flight;
   logic [CW-1:0] discard_cnt;
   logic [CW-1:0] fifo_count;
   logic [AW-1:0] tq_wr, tq_rd;
   logic [AW-1:0] fq_wr, fq_rd;
   logic [15:0]   tag_mem   [DEPTH];
   logic [15:0]   fifo_pc   [DEPTH];
   logic [15:0]   fifo_inst [DEPTH];
   logic [CW:0]   credit_sum;
   logic          req_fire;
   logic          rsp_fire;
   logic          rsp_keep;
   logic          pop;

   // Outstanding plus buffered fetches never exceed DEPTH, so every response
   // that is kept is guaranteed a free FIFO slot.
   assign credit_sum     = {1'b0, in_flight} + {1'b0, fifo_count};
   assign imem_req_valid = !reset && !redirect && (credit_sum < (CW+1)'(DEPTH));
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign pc_enable      = req_fire || (redirect && !reset);

   // A response with nothing outstanding (e.g. straggler across a reset) is
   // ignored entirely. Responses in the redirect cycle are always wrong-path.
   assign rsp_fire = imem_rsp_valid && (in_flight != '0);
   assign rsp_keep = rsp_fire && !redirect && (discard_cnt == '0);

   assign inst_valid = (fifo_count != '0);
   assign pop        = inst_valid && inst_ready;
   assign inst_data  = inst_valid ? fifo_inst[fq_rd] : '0;
   assign inst_pc    = inst_valid ? fifo_pc[fq_rd]   : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_flight   <= '0;
         discard_cnt <= '0;
         tq_wr       <= '0;
         tq_rd       <= '0;
         fq_wr       <= '0;
         fq_rd       <= '0;
         fifo_count  <= '0;
      end else begin
         in_flight <= in_flight + CW'(req_fire) - CW'(rsp_fire);
         if (req_fire) tq_wr <= tq_wr + AW'(1);
         if (rsp_fire) tq_rd <= tq_rd + AW'(1);

         // After a redirect every fetch still outstanding is wrong-path; no
         // request fires in the redirect cycle, so that is exactly the
         // post-edge in_flight. Earlier discards are a subset of these.
         if (redirect)
            discard_cnt <= in_flight - CW'(rsp_fire);
         else if (rsp_fire && (discard_cnt != '0))
            discard_cnt <= discard_cnt - CW'(1);

         if (redirect) begin
            fq_wr      <= '0;
            fq_rd      <= '0;
            fifo_count <= '0;
         end else begin
            if (rsp_keep) fq_wr <= fq_wr + AW'(1);
            if (pop)      fq_rd <= fq_rd + AW'(1);
            fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
         end
      end
   end

   // Storage arrays carry data only; validity lives in the pointers above.
   always_ff @(posedge clk) begin
      if (req_fire) tag_mem[tq_wr] <= pc;
      if (rsp_keep) begin
         fifo_pc[fq_wr]   <= tag_mem[tq_rd];
         fifo_inst[fq_wr] <= imem_rsp_data;
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      rsp_keep |-> (fifo_count != CW'(DEPTH)))
      else $error("ifetch16: response pushed into full instruction buffer");

endmodule
